// File: rtl/vga_timing.sv
// vga_timing: VGA raster generator. A programmable clock divider produces the
// pixel tick. Horizontal and vertical counters advance on that tick, and two
// phase FSMs decode hsync, vsync and bright. Every output is registered from
// next-state values, so sync, bright and the counters always describe the
// same pixel in the same cycle.
// Parameter limits: CLK_DIV in 1..16, every phase parameter >= 1, and both
// totals <= 2048.
module vga_timing #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic        clock,
   input  logic        reset,
   output logic        hsync,
   output logic        vsync,
   output logic        bright,
   output logic [10:0] pxcount,
   output logic [10:0] linecount,
   output logic        pixel_tick,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Last count of each phase; a phase FSM leaves its state on that count.
   localparam logic [10:0] H_ACT_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] H_FP_LAST   = 11'(H_ACTIVE + H_FP - 1);
   localparam logic [10:0] H_SYNC_LAST = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_ACT_LAST  = 11'(V_ACTIVE - 1);
   localparam logic [10:0] V_FP_LAST   = 11'(V_ACTIVE + V_FP - 1);
   localparam logic [10:0] V_SYNC_LAST = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);

   typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} hstate_t;
   typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} vstate_t;

   logic [DIV_W-1:0] div_q, div_d;
   logic [10:0]      px_q, px_d;
   logic [10:0]      ln_q, ln_d;
   hstate_t          hst_q, hst_d;
   vstate_t          vst_q, vst_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             bright_q, bright_d;
   logic             ptick_q;
   logic             fstart_q, fstart_d;
   logic             tick;
   logic             line_adv;

   // State register: divider, counters, phase FSMs and registered outputs.
   // Reset parks the raster on the last pixel so the first tick opens a frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         px_q     <= H_LAST;
         ln_q     <= V_LAST;
         hst_q    <= HS_BP;
         vst_q    <= VS_BP;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         bright_q <= 1'b0;
         ptick_q  <= 1'b0;
         fstart_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         px_q     <= px_d;
         ln_q     <= ln_d;
         hst_q    <= hst_d;
         vst_q    <= vst_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         bright_q <= bright_d;
         ptick_q  <= tick;
         fstart_q <= fstart_d;
      end
   end

   // Divider and raster counters; counters only move on the pixel tick.
   always_comb begin
      tick     = (div_q == DIV_LAST);
      div_d    = tick ? '0 : div_q + 1'b1;
      line_adv = tick && (px_q == H_LAST);
      px_d     = px_q;
      ln_d     = ln_q;
      if (tick) begin
         px_d = (px_q == H_LAST) ? '0 : px_q + 11'd1;
      end
      if (line_adv) begin
         ln_d = (ln_q == V_LAST) ? '0 : ln_q + 11'd1;
      end
      fstart_d = line_adv && (ln_q == V_LAST);
   end

   // Next-state logic for both phase FSMs.
   always_comb begin
      hst_d = hst_q;
      vst_d = vst_q;
      if (tick) begin
         case (hst_q)
            HS_ACT:  if (px_q == H_ACT_LAST)  hst_d = HS_FP;
            HS_FP:   if (px_q == H_FP_LAST)   hst_d = HS_SYNC;
            HS_SYNC: if (px_q == H_SYNC_LAST) hst_d = HS_BP;
            HS_BP:   if (px_q == H_LAST)      hst_d = HS_ACT;
            default: hst_d = HS_BP;
         endcase
      end
      if (line_adv) begin
         case (vst_q)
            VS_ACT:  if (ln_q == V_ACT_LAST)  vst_d = VS_FP;
            VS_FP:   if (ln_q == V_FP_LAST)   vst_d = VS_SYNC;
            VS_SYNC: if (ln_q == V_SYNC_LAST) vst_d = VS_BP;
            VS_BP:   if (ln_q == V_LAST)      vst_d = VS_ACT;
            default: vst_d = VS_BP;
         endcase
      end
   end

   // Output decode from next state, so outputs line up with the new counters.
   always_comb begin
      hsync_d  = (hst_d != HS_SYNC);
      vsync_d  = (vst_d != VS_SYNC);
      bright_d = (hst_d == HS_ACT) && (vst_d == VS_ACT);
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign bright      = bright_q;
   assign pxcount     = px_q;
   assign linecount   = ln_q;
   assign pixel_tick  = ptick_q;
   assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three vga_timing instances (default 640x480 timing, a tiny
// CLK_DIV=1 raster, and a CLK_DIV=3 raster) checked against a closed-form
// model. The model turns "clock edges since reset release" into a tick count
// and derives the pixel position and sync/bright flags from it arithmetically.
module tb_vga_timing;

   typedef struct packed {
      logic [10:0] px;
      logic [10:0] ln;
      logic        hs;
      logic        vs;
      logic        br;
      logic        pt;
      logic        fs;
   } obs_t;

   typedef struct packed {
      int dv; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
   } cfg_t;

   logic clock = 1'b0;
   logic rst_def = 1'b1, rst_sm = 1'b1, rst_mid = 1'b1;

   logic        hs_def, vs_def, br_def, pt_def, fs_def;
   logic [10:0] px_def, ln_def;
   logic        hs_sm, vs_sm, br_sm, pt_sm, fs_sm;
   logic [10:0] px_sm, ln_sm;
   logic        hs_mid, vs_mid, br_mid, pt_mid, fs_mid;
   logic [10:0] px_mid, ln_mid;

   int checks = 0;
   int failures = 0;
   int n_def = 0, n_sm = 0, n_mid = 0;

   always #5 clock = ~clock;

   vga_timing u_def (
      .clock(clock), .reset(rst_def), .hsync(hs_def), .vsync(vs_def),
      .bright(br_def), .pxcount(px_def), .linecount(ln_def),
      .pixel_tick(pt_def), .frame_start(fs_def)
   );

   vga_timing #(
      .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) u_sm (
      .clock(clock), .reset(rst_sm), .hsync(hs_sm), .vsync(vs_sm),
      .bright(br_sm), .pxcount(px_sm), .linecount(ln_sm),
      .pixel_tick(pt_sm), .frame_start(fs_sm)
   );

   vga_timing #(
      .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_mid (
      .clock(clock), .reset(rst_mid), .hsync(hs_mid), .vsync(vs_mid),
      .bright(br_mid), .pxcount(px_mid), .linecount(ln_mid),
      .pixel_tick(pt_mid), .frame_start(fs_mid)
   );

   function automatic cfg_t get_cfg(input int inst);
      case (inst)
         0:       return '{dv:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33};
         1:       return '{dv:1, ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1};
         default: return '{dv:3, ha:6, hf:2, hs:3, hb:2, va:4, vf:2, vs:2, vb:3};
      endcase
   endfunction

   function automatic obs_t get_obs(input int inst);
      case (inst)
         0:       return {px_def, ln_def, hs_def, vs_def, br_def, pt_def, fs_def};
         1:       return {px_sm, ln_sm, hs_sm, vs_sm, br_sm, pt_sm, fs_sm};
         default: return {px_mid, ln_mid, hs_mid, vs_mid, br_mid, pt_mid, fs_mid};
      endcase
   endfunction

   // n = rising edges since reset release. k ticks have happened; pixel index
   // in the frame is k-1 (modulo the frame), with -1 meaning the last pixel.
   function automatic obs_t model(input int inst, input int n);
      cfg_t c;
      obs_t m;
      int ht, vt, tot, k, a, px, ln;
      c   = get_cfg(inst);
      ht  = c.ha + c.hf + c.hs + c.hb;
      vt  = c.va + c.vf + c.vs + c.vb;
      tot = ht * vt;
      k   = n / c.dv;
      a   = ((k % tot) + tot - 1) % tot;
      px  = a % ht;
      ln  = a / ht;
      m.px = 11'(px);
      m.ln = 11'(ln);
      m.hs = (px >= c.ha + c.hf && px < c.ha + c.hf + c.hs) ? 1'b0 : 1'b1;
      m.vs = (ln >= c.va + c.vf && ln < c.va + c.vf + c.vs) ? 1'b0 : 1'b1;
      m.br = (px < c.ha && ln < c.va) ? 1'b1 : 1'b0;
      m.pt = (n > 0 && (n % c.dv) == 0) ? 1'b1 : 1'b0;
      m.fs = (m.pt && a == 0) ? 1'b1 : 1'b0;
      return m;
   endfunction

   task automatic test_reset();
      obs_t o, e;
      rst_def = 1'b1;
      repeat (5) @(negedge clock);
      rst_def = 1'b0;
      n_def = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(negedge clock);
            n_def++;
         end else begin
            #1;
         end
         case (i)
            0, 1:    e = {11'd799, 11'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            2:       e = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            3:       e = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            default: e = {11'd1, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         endcase
         o = get_obs(0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset_release edge=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                     i, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
         end
      end
   endtask

   task automatic test_line();
      obs_t o, e, prev;
      int hs_low = 0, br_cnt = 0, adv = 0;
      prev = get_obs(0);
      while (n_def < 3300) begin
         @(negedge clock);
         n_def++;
         o = get_obs(0);
         e = model(0, n_def);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL line_model n=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                     n_def, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
         end
         if (o.ln == 11'd1) begin
            if (!o.hs) hs_low++;
            if (o.br) br_cnt++;
         end
         if (o.ln != prev.ln) begin
            adv++;
            checks++;
            if (!(prev.px == 11'd799 && o.px == 11'd0)) begin
               failures++;
               $display("FAIL line_advance got px %0d->%0d required 799->0", prev.px, o.px);
            end
         end
         prev = o;
      end
      checks++;
      if (hs_low != 192) begin
         failures++;
         $display("FAIL hsync_low_clocks got %0d required 192", hs_low);
      end
      checks++;
      if (br_cnt != 1280) begin
         failures++;
         $display("FAIL bright_clocks_line got %0d required 1280", br_cnt);
      end
      checks++;
      if (adv != 2) begin
         failures++;
         $display("FAIL line_advances got %0d required 2", adv);
      end
   endtask

   task automatic test_async_reset_default();
      obs_t o, e;
      int waited = 0;
      while (px_def != 11'd700 && waited < 2000) begin
         @(negedge clock);
         n_def++;
         waited++;
      end
      checks++;
      if (px_def != 11'd700 || hs_def !== 1'b0) begin
         failures++;
         $display("FAIL wait_px700 got px=%0d hs=%b required px=700 hs=0", px_def, hs_def);
      end
      #2 rst_def = 1'b1;
      #1;
      o = get_obs(0);
      e = {11'd799, 11'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL async_reset_def got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                  o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
      end
   endtask

   task automatic test_small_frames();
      obs_t o, e, prev;
      int fs_n[$];
      int adv_n[$];
      rst_sm = 1'b1;
      repeat (3) @(negedge clock);
      rst_sm = 1'b0;
      n_sm = 0;
      #1;
      prev = get_obs(1);
      while (n_sm < 98) begin
         @(negedge clock);
         n_sm++;
         o = get_obs(1);
         e = model(1, n_sm);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL small_model n=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                     n_sm, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
         end
         if (o.fs) fs_n.push_back(n_sm);
         if (o.ln != prev.ln && n_sm > 1) adv_n.push_back(n_sm);
         prev = o;
      end
      checks++;
      if (fs_n.size() != 3 || fs_n[0] != 1 || fs_n[1] != 49 || fs_n[2] != 97) begin
         failures++;
         $display("FAIL small_frame_start got count=%0d required pulses at edges 1,49,97", fs_n.size());
      end
      for (int i = 1; i < adv_n.size(); i++) begin
         checks++;
         if (adv_n[i] - adv_n[i-1] != 8) begin
            failures++;
            $display("FAIL small_line_period got %0d required 8", adv_n[i] - adv_n[i-1]);
         end
      end
   endtask

   task automatic test_async_reset_small();
      obs_t o, e;
      int waited = 0;
      while (!(hs_sm === 1'b0 && vs_sm === 1'b0) && waited < 100) begin
         @(negedge clock);
         n_sm++;
         waited++;
      end
      checks++;
      if (!(hs_sm === 1'b0 && vs_sm === 1'b0)) begin
         failures++;
         $display("FAIL wait_small_sync got hs=%b vs=%b required 0 0", hs_sm, vs_sm);
      end
      #2 rst_sm = 1'b1;
      e = {11'd7, 11'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
         if (i == 0) #1;
         else @(negedge clock);
         o = get_obs(1);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL async_reset_small step=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                     i, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
         end
      end
   endtask

   task automatic test_random_mid();
      obs_t o, e;
      int run_len;
      for (int it = 0; it < 8; it++) begin
         rst_mid = 1'b1;
         repeat ($urandom_range(1, 4)) @(negedge clock);
         rst_mid = 1'b0;
         n_mid = 0;
         run_len = $urandom_range(10, 900);
         for (int c = 0; c < run_len; c++) begin
            @(negedge clock);
            n_mid++;
            o = get_obs(2);
            e = model(2, n_mid);
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL mid_model it=%0d n=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                        it, n_mid, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
            end
         end
         #($urandom_range(1, 3)) rst_mid = 1'b1;
         #1;
         o = get_obs(2);
         e = model(2, 0);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL mid_async_reset it=%0d got px=%0d ln=%0d hvbpf=%b exp px=%0d ln=%0d hvbpf=%b",
                     it, o.px, o.ln, o[4:0], e.px, e.ln, e[4:0]);
         end
         @(negedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_async_reset_default();
      test_small_frames();
      test_async_reset_small();
      test_random_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
